bram_capture_ctrl: RTL and testbench
====================================

Name: bram_capture_ctrl

Overview:
- Downstream acquisition stage that writes a validated sample stream into a single-port BRAM write interface.
- Sequence: arm on a start pulse, wait for an optional external trigger, apply a programmable post-trigger delay, then write exactly 2^BRAM_WIDTH samples from address 0 up to the top address.
- Provides registered BRAM write signals plus status (busy, done, state) for the software-visible status registers.

Parameters:
- BRAM_WIDTH, 13, BRAM address width; capture length = 2^BRAM_WIDTH samples.
- DATA_WIDTH, 32, sample / BRAM data width.
- DELAY_WIDTH, 16, width of the post-trigger delay count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start_acq  in  1  single-cycle arm/restart pulse.
- trig_en  in  1  1: wait for a trig rising edge; 0: trigger immediately once armed.
- trig  in  1  external trigger level, already synchronous to clk.
- delay  in  DELAY_WIDTH  post-trigger delay in valid-independent clk cycles; sampled on trigger.
- din  in  DATA_WIDTH  sample data.
- din_valid  in  1  din qualifier.
- bram_addr  out  BRAM_WIDTH  BRAM write address (registered).
- bram_wdata  out  DATA_WIDTH  BRAM write data (registered).
- bram_we  out  1  BRAM write enable (registered).
- busy  out  1  high in ARMED, DELAY or CAPTURE.
- done  out  1  sticky; set when the capture completes, cleared by start_acq or rst.
- state  out  2  IDLE=0, ARMED=1, DELAY=2, CAPTURE=3.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State=IDLE; bram_addr=0, bram_wdata=0, bram_we=0, busy=0, done=0.
  - Internal write pointer=0, delay counter=0, trig_d=0.
  - rst overrides every other input, including in mid-capture.
- Trigger edge detection:
  - trig_d <= trig every cycle.
  - trig_edge = trig & ~trig_d.
- start_acq has priority over all transitions in every state except reset:
  - Next state=ARMED; done<=0; write pointer<=0; bram_we<=0 for that cycle.
  - A start_acq on the final capture cycle aborts that write and leaves done=0.
- IDLE:
  - bram_we=0; wait for start_acq.
- ARMED: fire condition is (trig_en=0) or trig_edge.
  - On fire with delay=0: go to CAPTURE.
  - On fire with delay!=0: load counter with delay-1 and go to DELAY.
  - An edge in the same cycle as start_acq is ignored, because start_acq priority means a new arm.
- DELAY:
  - If counter=0, go to CAPTURE; otherwise decrement the counter.
  - Exactly `delay` cycles are spent in DELAY.
  - din_valid is ignored and trig edges are ignored.
- CAPTURE:
  - On a cycle with din_valid=1: bram_we<=1, bram_addr<=pointer, bram_wdata<=din, pointer<=pointer+1.
  - On a cycle with din_valid=0: bram_we<=0; pointer, bram_addr and bram_wdata hold.
  - When a write is issued with pointer = all-ones: next state=IDLE, done<=1, pointer wraps to 0.
  - Trig edges are ignored.
- Latency: one cycle from din/din_valid to bram_wdata/bram_we.
  - bram_we is high for exactly 2^BRAM_WIDTH cycles per capture.
  - Addresses are issued strictly increasing from 0 with no gaps and no repeats.
- Outside CAPTURE, bram_we<=0 every cycle.
- busy and state are combinational decodes of the state register, so they update in the cycle after the transition edge.
- delay is sampled only at the ARMED->DELAY transition; later changes have no effect.
- trig_en is sampled each cycle in ARMED only.

Test Plan (BRAM_WIDTH=4, DATA_WIDTH=8, DELAY_WIDTH=4):
- Basic capture:
  - Stimulus: rst, then start_acq, trig_en=0, delay=0, din_valid=1, din = cycle count.
  - Required: state ARMED->CAPTURE; 16 consecutive bram_we pulses, addr 0..15, each wdata = the din value one cycle earlier; then done=1, busy=0, state=0.
- Triggered with delay:
  - Stimulus: trig_en=1, delay=5; trig held high before arming, then low, then a rising edge at cycle T.
  - Required: no capture from the pre-high level; state=DELAY for 5 cycles; first bram_we with addr 0 exactly 7 cycles after edge T.
- Gapped valid:
  - Stimulus: din_valid toggles 1,0,1,0 during CAPTURE.
  - Required: bram_we follows din_valid delayed by one cycle; addr holds across the gaps; done after the 16th valid sample only.
- Restart mid-capture:
  - Stimulus: start_acq after addr 9 has been written.
  - Required: bram_we=0 next cycle; state=ARMED; done=0; the next capture starts at addr 0.
- start_acq on the final sample:
  - Stimulus: start_acq coincident with the din_valid for pointer=15.
  - Required: no write to addr 15; done stays 0; state=ARMED.
- Reset mid-DELAY:
  - Stimulus: rst=1 during DELAY.
  - Required: all outputs 0, state=IDLE; a later trig edge with no start_acq causes no writes.

Source files
------------

// File: rtl/bram_capture_ctrl.sv
// Capture controller: arm on start_acq, wait for an optional trigger and a post-trigger
// delay, then write exactly 2^BRAM_WIDTH valid samples into a single-port BRAM.
module bram_capture_ctrl #(
    parameter int BRAM_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_acq,
    input  logic                   trig_en,
    input  logic                   trig,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   din_valid,
    output logic [BRAM_WIDTH-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_wdata,
    output logic                   bram_we,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DELAY   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BRAM_WIDTH-1:0]  ptr_q, ptr_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   trig_d_q;
    logic [BRAM_WIDTH-1:0]  bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0]  bram_wdata_q, bram_wdata_d;
    logic                   bram_we_q, bram_we_d;
    logic                   done_q, done_d;
    logic                   trig_edge;

    assign trig_edge = trig & ~trig_d_q;

    // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        bram_we_d    = 1'b0;
        done_d       = done_q;

        if (start_acq) begin
            // A new arm wins over everything, including the last write of a capture.
            state_d = ST_ARMED;
            done_d  = 1'b0;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (!trig_en || trig_edge) begin
                        if (delay == '0) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            cnt_d   = delay - DELAY_WIDTH'(1);
                            state_d = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) state_d = ST_CAPTURE;
                    else             cnt_d   = cnt_q - DELAY_WIDTH'(1);
                end
                ST_CAPTURE: begin
                    if (din_valid) begin
                        bram_we_d    = 1'b1;
                        bram_addr_d  = ptr_q;
                        bram_wdata_d = din;
                        ptr_d        = ptr_q + BRAM_WIDTH'(1);
                        if (&ptr_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            trig_d_q     <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            bram_we_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            trig_d_q     <= trig;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_we_q    <= bram_we_d;
            done_q       <= done_d;
        end
    end

    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_we    = bram_we_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign state      = state_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Directed-plus-random bench for bram_capture_ctrl (16-entry BRAM) against a
// behavioural model that tracks the capture phase, remaining wait and sample count.
module tb_bram_capture_ctrl;

    localparam int BW = 4;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int DEPTH = 1 << BW;

    logic          clk = 1'b0;
    logic          rst, start_acq, trig_en, trig, din_valid;
    logic [LW-1:0] delay;
    logic [DW-1:0] din;
    logic [BW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          bram_we, busy, done;
    logic [1:0]    state;

    bram_capture_ctrl #(.BRAM_WIDTH(BW), .DATA_WIDTH(DW), .DELAY_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start_acq(start_acq), .trig_en(trig_en), .trig(trig),
        .delay(delay), .din(din), .din_valid(din_valid), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_we(bram_we), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int cyc = 0;

    // Behavioural model: phase (0 idle,1 armed,2 waiting,3 capturing), cycles left to wait,
    // number of samples already stored, and the expected write-port outputs.
    int            m_phase, m_remain, m_stored;
    logic          m_trig_prev, m_we, m_done;
    logic [BW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        logic rise;
        if (rst) begin
            m_phase = 0; m_remain = 0; m_stored = 0; m_trig_prev = 1'b0;
            m_we = 1'b0; m_done = 1'b0; m_addr = '0; m_wdata = '0;
        end else begin
            rise = trig && !m_trig_prev;
            m_trig_prev = trig;
            m_we = 1'b0;
            if (start_acq) begin
                m_phase = 1; m_done = 1'b0; m_stored = 0;
            end else if (m_phase == 1) begin
                if (!trig_en || rise) begin
                    m_remain = int'(delay);
                    m_phase  = (m_remain == 0) ? 3 : 2;
                end
            end else if (m_phase == 2) begin
                m_remain--;
                if (m_remain == 0) m_phase = 3;
            end else if (m_phase == 3 && din_valid) begin
                m_we = 1'b1;
                m_addr = BW'(m_stored);
                m_wdata = din;
                m_stored++;
                if (m_stored == DEPTH) begin
                    m_phase = 0; m_done = 1'b1; m_stored = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        if (bram_we === 1'b1) we_cnt++;
        check("state", 32'(state), 32'(m_phase));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_done));
        check("we", 32'(bram_we), 32'(m_we));
        check("addr", 32'(bram_addr), 32'(m_addr));
        check("wdata", 32'(bram_wdata), 32'(m_wdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int lat;
        rst = 1'b1; start_acq = 1'b0; trig_en = 1'b0; trig = 1'b1; delay = '0;
        din = 8'hA5; din_valid = 1'b1;

        // Reset state
        repeat (2) cycle();
        check("reset_state", 32'(state), 32'd0);
        rst = 1'b0; trig = 1'b0;
        cycle();

        // Basic capture: free-running trigger, no delay, continuous valid
        we_cnt = 0;
        start_acq = 1'b1; din = 8'(cyc); cycle();
        start_acq = 1'b0;
        check("basic_armed", 32'(state), 32'd1);
        repeat (20) begin din = 8'(cyc); cycle(); end
        check("basic_we_count", 32'(we_cnt), 32'd16);
        check("basic_done", 32'(done), 32'd1);
        check("basic_idle", 32'(state), 32'd0);

        // Triggered with delay 5: trig high before arming must not fire
        trig_en = 1'b1; delay = 4'd5; trig = 1'b1;
        repeat (2) cycle();
        start_acq = 1'b1; cycle();
        start_acq = 1'b0;
        repeat (3) cycle();
        check("trig_level_no_fire", 32'(state), 32'd1);
        trig = 1'b0; repeat (2) cycle();
        trig = 1'b1; lat = 0; we_cnt = 0;
        guard = 0;
        while (bram_we !== 1'b1 && guard < 20) begin
            din = 8'($urandom); cycle(); lat++; guard++;
            if (lat == 5) check("in_delay", 32'(state), 32'd2);
        end
        check("trig_latency", 32'(lat), 32'd7);
        check("trig_first_addr", 32'(bram_addr), 32'd0);
        delay = 4'd9;
        guard = 0;
        while (m_phase != 0 && guard < 40) begin din = 8'($urandom); cycle(); guard++; end
        check("trig_we_count", 32'(we_cnt), 32'd16);

        // Gapped valid with a small random delay
        trig_en = 1'b0; delay = 4'($urandom_range(0, 3)); we_cnt = 0;
        start_acq = 1'b1; cycle();
        start_acq = 1'b0; din_valid = 1'b1;
        guard = 0;
        while (m_phase != 0 && guard < 80) begin
            din = 8'($urandom); cycle(); din_valid = ~din_valid; guard++;
        end
        check("gap_we_count", 32'(we_cnt), 32'd16);
        check("gap_done", 32'(done), 32'd1);

        // Restart after address 9 has been written
        delay = '0; din_valid = 1'b1;
        start_acq = 1'b1; cycle();
        start_acq = 1'b0;
        guard = 0;
        while (!(bram_we === 1'b1 && bram_addr === 4'd9) && guard < 40) begin
            din = 8'($urandom); cycle(); guard++;
        end
        check("restart_reached9", 32'(bram_addr), 32'd9);
        start_acq = 1'b1; cycle();
        start_acq = 1'b0;
        check("restart_we", 32'(bram_we), 32'd0);
        check("restart_state", 32'(state), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        cycle();
        din = 8'($urandom); cycle();
        check("restart_addr0", 32'(bram_addr), 32'd0);

        // start_acq coincident with the final sample
        guard = 0;
        while (!(m_phase == 3 && m_stored == DEPTH - 1) && guard < 80) begin
            din = 8'($urandom); din_valid = 1'($urandom); cycle(); guard++;
        end
        din_valid = 1'b1; start_acq = 1'b1; cycle();
        start_acq = 1'b0;
        check("final_abort_we", 32'(bram_we), 32'd0);
        check("final_abort_done", 32'(done), 32'd0);
        check("final_abort_state", 32'(state), 32'd1);

        // Reset in the middle of DELAY, then a trigger edge without arming
        trig_en = 1'b1; delay = 4'd10; trig = 1'b0; cycle();
        trig = 1'b1; repeat (4) cycle();
        check("pre_reset_delay", 32'(state), 32'd2);
        rst = 1'b1; cycle();
        rst = 1'b0; trig = 1'b0; we_cnt = 0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        cycle();
        trig = 1'b1;
        repeat (30) begin din = 8'($urandom); cycle(); end
        check("rst_no_writes", 32'(we_cnt), 32'd0);

        // Random soak
        repeat (400) begin
            rst       = ($urandom_range(0, 149) == 0);
            start_acq = ($urandom_range(0, 39) == 0);
            trig_en   = 1'($urandom);
            trig      = ($urandom_range(0, 3) == 0) ? ~trig : trig;
            delay     = 4'($urandom_range(0, 6));
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
